// File: rtl/bsg_sipo_yumi_pkg.sv
// Shared definitions for the serial-in parallel-out deserializer.
package bsg_sipo_yumi_pkg;

    localparam int unsigned frame_count_width = 16;

    // Word counter width: ceil(log2(els)), never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned els);
        return (els > 1) ? int'($clog2(els)) : 1;
    endfunction

endpackage

// File: rtl/bsg_sipo_yumi_ctr.sv
// Word position counter: counts 0..els_p-1 on each accepted word, flags the last slot.
module bsg_sipo_yumi_ctr
    import bsg_sipo_yumi_pkg::*;
#(
    parameter int unsigned els_p = 4,
    localparam int unsigned ctr_w = ctr_width(els_p)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             incr_i,
    output logic [ctr_w-1:0] count_o,
    output logic             last_c
);

    logic [ctr_w-1:0] count_r;

    assign last_c  = (count_r == ctr_w'(els_p - 1));
    assign count_o = count_r;

    // With els_p=1 last_c is always set, so the counter stays at 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (incr_i) begin
            count_r <= last_c ? '0 : count_r + ctr_w'(1);
        end
    end

endmodule

// File: rtl/bsg_serial_in_parallel_out_yumi.sv
// Packs els_p valid/yumi serial words into a ready/valid parallel frame.
// Optional BSG_SIPO_YUMI_FRAME_COUNT_EN adds a 16-bit dequeued-frame counter.
module bsg_serial_in_parallel_out_yumi
    import bsg_sipo_yumi_pkg::*;
#(
    parameter int unsigned width_p                 = 16,
    parameter int unsigned els_p                   = 4,
    parameter int unsigned hi_to_lo_p              = 0,
    parameter int unsigned use_minimal_buffering_p = 0
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            valid_i,
    input  logic [width_p-1:0]              data_i,
    output logic                            yumi_o,
    output logic                            valid_o,
    output logic [els_p-1:0][width_p-1:0]   data_o,
    input  logic                            ready_and_i
`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
   ,output logic [frame_count_width-1:0]    frame_count_o
`endif
);

    localparam int unsigned ctr_w = ctr_width(els_p);

    logic [ctr_w-1:0]               ctr_r;
    logic                           last_c;
    logic [ctr_w-1:0]               slot_c;
    logic                           yumi_c;
    logic [els_p-1:0][width_p-1:0]  asm_r;

    bsg_sipo_yumi_ctr #(
        .els_p (els_p)
    ) u_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .incr_i    (yumi_c),
        .count_o   (ctr_r),
        .last_c    (last_c)
    );

    assign slot_c = (hi_to_lo_p != 0) ? ctr_w'(els_p - 1) - ctr_r : ctr_r;
    assign yumi_o = yumi_c;

    // Assembly buffer holds no control state, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (yumi_c) begin
            asm_r[slot_c] <= data_i;
        end
    end

    if (use_minimal_buffering_p == 0) begin : g_full
        logic                           out_v_r;
        logic [els_p-1:0][width_p-1:0]  out_r;
        logic [els_p-1:0][width_p-1:0]  merged_c;

        // Last word bypasses the assembly buffer straight into the output register.
        always_comb begin
            merged_c         = asm_r;
            merged_c[slot_c] = data_i;
        end

        assign yumi_c = reset_n_i & valid_i & (~last_c | ~out_v_r | ready_and_i);

        // A completing frame takes priority over the dequeue of the old one.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                out_v_r <= 1'b0;
            end else if (yumi_c & last_c) begin
                out_v_r <= 1'b1;
            end else if (ready_and_i & out_v_r) begin
                out_v_r <= 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (yumi_c & last_c) begin
                out_r <= merged_c;
            end
        end

        assign valid_o = out_v_r;
        assign data_o  = out_r;
    end else begin : g_min
        logic full_r;

        assign yumi_c = reset_n_i & valid_i & ~full_r;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                full_r <= 1'b0;
            end else if (yumi_c & last_c) begin
                full_r <= 1'b1;
            end else if (ready_and_i & full_r) begin
                full_r <= 1'b0;
            end
        end

        assign valid_o = full_r;
        assign data_o  = asm_r;
    end

`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
    logic [frame_count_width-1:0] frame_count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            frame_count_r <= '0;
        end else if (valid_o & ready_and_i) begin
            frame_count_r <= frame_count_r + frame_count_width'(1);
        end
    end

    assign frame_count_o = frame_count_r;
`endif

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_yumi.sv
// Bench for the deserializer: three configurations checked against a queue-style frame model.
module tb_bsg_serial_in_parallel_out_yumi;

    localparam int W = 16;
    localparam int E = 4;
    localparam int N = 3;   // 0: full, lo-first  1: full, hi-first  2: minimal buffering

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           valid;
    logic [W-1:0]           data  [N];
    logic [N-1:0]           ready;
    logic [N-1:0]           yumi;
    logic [N-1:0]           vo;
    logic [E-1:0][W-1:0]    dout  [N];
`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
    logic [15:0]            fc    [N];
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: words collected so far, and the frame on offer.
    logic [W-1:0]           part_w   [N][E];
    int                     part_n   [N];
    bit                     ov       [N];
    logic [E-1:0][W-1:0]    of       [N];
    bit                     hold     [N];
    logic [W-1:0]           nxt      [N];
    int                     yumi_cnt [N];
    logic [15:0]            fc_exp   [N];

    bsg_serial_in_parallel_out_yumi #(.width_p(W), .els_p(E), .hi_to_lo_p(0), .use_minimal_buffering_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(valid[0]), .data_i(data[0]), .yumi_o(yumi[0]),
        .valid_o(vo[0]), .data_o(dout[0]), .ready_and_i(ready[0])
`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
       ,.frame_count_o(fc[0])
`endif
    );

    bsg_serial_in_parallel_out_yumi #(.width_p(W), .els_p(E), .hi_to_lo_p(1), .use_minimal_buffering_p(0)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(valid[1]), .data_i(data[1]), .yumi_o(yumi[1]),
        .valid_o(vo[1]), .data_o(dout[1]), .ready_and_i(ready[1])
`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
       ,.frame_count_o(fc[1])
`endif
    );

    bsg_serial_in_parallel_out_yumi #(.width_p(W), .els_p(E), .hi_to_lo_p(0), .use_minimal_buffering_p(1)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(valid[2]), .data_i(data[2]), .yumi_o(yumi[2]),
        .valid_o(vo[2]), .data_o(dout[2]), .ready_and_i(ready[2])
`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
       ,.frame_count_o(fc[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; outputs compared at the falling edge, model advanced at the rising edge.
    task automatic drive_cycle(input int vprob, input int rprob);
        bit ey [N];
        for (int d = 0; d < N; d++) begin
            if (!hold[d]) begin
                valid[d] = (int'($urandom_range(99)) < vprob);
                data[d]  = nxt[d];
            end
            ready[d] = (int'($urandom_range(99)) < rprob);
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            if (d == 2) ey[d] = valid[d] && !ov[d];
            else        ey[d] = valid[d] && (part_n[d] < E - 1 || !ov[d] || ready[d]);
            checks++;
            if (yumi[d] !== ey[d]) begin
                errors++;
                $display("FAIL yumi dut%0d t=%0t got=%b exp=%b", d, $time, yumi[d], ey[d]);
            end
            checks++;
            if (vo[d] !== ov[d]) begin
                errors++;
                $display("FAIL valid_o dut%0d t=%0t got=%b exp=%b", d, $time, vo[d], ov[d]);
            end
            if (ov[d]) begin
                checks++;
                if (dout[d] !== of[d]) begin
                    errors++;
                    $display("FAIL data_o dut%0d t=%0t got=%h exp=%h", d, $time, dout[d], of[d]);
                end
            end
`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
            checks++;
            if (fc[d] !== fc_exp[d]) begin
                errors++;
                $display("FAIL frame_count dut%0d t=%0t got=%0d exp=%0d", d, $time, fc[d], fc_exp[d]);
            end
`endif
            yumi_cnt[d] += (yumi[d] === 1'b1) ? 1 : 0;
        end
        @(posedge clk);
        for (int d = 0; d < N; d++) begin
            if (ov[d] && ready[d]) begin
                ov[d] = 1'b0;
                fc_exp[d] = fc_exp[d] + 16'd1;
            end
            if (ey[d]) begin
                part_w[d][part_n[d]] = data[d];
                part_n[d]++;
                nxt[d] = W'($urandom);
                if (part_n[d] == E) begin
                    for (int k = 0; k < E; k++) of[d][(d == 1) ? E - 1 - k : k] = part_w[d][k];
                    ov[d]     = 1'b1;
                    part_n[d] = 0;
                end
            end
            hold[d] = valid[d] && !ey[d];
        end
        #1;
    endtask

    task automatic test_reset();
        valid = '1;
        ready = '0;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                checks++;
                if (yumi[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_yumi dut%0d got=%b exp=0", d, yumi[d]);
                end
                checks++;
                if (vo[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_valid dut%0d got=%b exp=0", d, vo[d]);
                end
            end
        end
        rst_n = 1'b1;
        valid = '0;
        for (int d = 0; d < N; d++) begin
            part_n[d]   = 0;
            ov[d]       = 1'b0;
            hold[d]     = 1'b0;
            yumi_cnt[d] = 0;
            fc_exp[d]   = 16'd0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_rate();
        int exp_cnt [N];
        exp_cnt = '{20, 20, 16};
        test_reset();
        repeat (20) drive_cycle(100, 100);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (yumi_cnt[d] !== exp_cnt[d]) begin
                errors++;
                $display("FAIL full_rate_yumis dut%0d got=%0d exp=%0d", d, yumi_cnt[d], exp_cnt[d]);
            end
        end
    endtask

    task automatic test_hi_to_lo();
        logic [W-1:0] w0 [E];
        logic [W-1:0] w1 [E];
        test_reset();
        for (int k = 0; k < E; k++) begin
            drive_cycle(100, 0);
            w0[k] = data[0];
            w1[k] = data[1];
        end
        valid = '0;
        @(negedge clk);
        checks++;
        if (vo[1] !== 1'b1 || dout[1][3] !== w1[0] || dout[1][0] !== w1[3]) begin
            errors++;
            $display("FAIL hi_to_lo got v=%b d3=%h d0=%h exp v=1 d3=%h d0=%h", vo[1], dout[1][3], dout[1][0], w1[0], w1[3]);
        end
        checks++;
        if (vo[0] !== 1'b1 || dout[0][0] !== w0[0] || dout[0][3] !== w0[3]) begin
            errors++;
            $display("FAIL lo_to_hi got v=%b d0=%h d3=%h exp v=1 d0=%h d3=%h", vo[0], dout[0][0], dout[0][3], w0[0], w0[3]);
        end
    endtask

    task automatic test_backpressure();
        test_reset();
        repeat (8) drive_cycle(100, 0);
        checks++;
        if (yumi_cnt[0] !== 7) begin
            errors++;
            $display("FAIL bp_stall_full got=%0d exp=7", yumi_cnt[0]);
        end
        checks++;
        if (yumi_cnt[2] !== 4) begin
            errors++;
            $display("FAIL bp_stall_min got=%0d exp=4", yumi_cnt[2]);
        end
        drive_cycle(100, 100);
        checks++;
        if (yumi_cnt[0] !== 8) begin
            errors++;
            $display("FAIL bp_release_yumi got=%0d exp=8", yumi_cnt[0]);
        end
        valid = '0;
        @(negedge clk);
        checks++;
        if (vo[0] !== 1'b1 || dout[0] !== of[0]) begin
            errors++;
            $display("FAIL bp_frame2 got v=%b d=%h exp v=1 d=%h", vo[0], dout[0], of[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] first;
        test_reset();
        repeat (2) drive_cycle(100, 100);
        test_reset();
        drive_cycle(100, 100);
        first = data[0];
        repeat (3) drive_cycle(100, 100);
        valid = '0;
        @(negedge clk);
        checks++;
        if (vo[0] !== 1'b1 || dout[0][0] !== first || dout[0] !== of[0]) begin
            errors++;
            $display("FAIL mid_reset_frame got v=%b d=%h exp v=1 d=%h", vo[0], dout[0], of[0]);
        end
    endtask

    task automatic test_random();
        test_reset();
        repeat (300) drive_cycle(70, 60);
        repeat (100) drive_cycle(90, 30);
        repeat (100) drive_cycle(100, 100);
    endtask

`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
    task automatic test_frame_count();
        test_reset();
        repeat (16) drive_cycle(100, 100);
        checks++;
        if (fc[0] !== 16'd3) begin
            errors++;
            $display("FAIL frame_count_three got=%0d exp=3", fc[0]);
        end
        test_reset();
        repeat (4) drive_cycle(100, 0);
        force dut0.frame_count_r = 16'hFFFF;
        #1;
        release dut0.frame_count_r;
        fc_exp[0] = 16'hFFFF;
        drive_cycle(0, 0);
        drive_cycle(0, 100);
        drive_cycle(0, 0);
        checks++;
        if (fc[0] !== 16'd0) begin
            errors++;
            $display("FAIL frame_count_wrap got=%h exp=0000", fc[0]);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        valid = '0;
        ready = '0;
        for (int d = 0; d < N; d++) begin
            data[d] = '0;
            nxt[d]  = W'($urandom);
        end
        test_reset();
        test_full_rate();
        test_hi_to_lo();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
`ifdef BSG_SIPO_YUMI_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_serial_in_parallel_out_yumi.md
Name: bsg_serial_in_parallel_out_yumi

Overview:
Deserializer that sits directly downstream of the team's parallel-in-serial-out stage. It consumes that stage's valid-then-yumi serial word stream, producing the yumi. It packs els_p consecutive words into one parallel frame and presents the frame on a ready/valid output channel. With full buffering it sustains one word per cycle at the input.

Parameters:
width_p, 16, bits per serial word
els_p, 4, words per parallel frame; legal range 1 or more
hi_to_lo_p, 0, 0: first received word lands in data_o[0]; 1: first word lands in data_o[els_p-1]
use_minimal_buffering_p, 0, 0: assembly buffer plus output register (full rate); 1: assembly buffer only (one-cycle bubble per frame)

Ports:
clk_i  input  1  clock, rising edge
reset_n_i  input  1  asynchronous, active-low reset
valid_i  input  1  serial word available (upstream holds data_i until yumi_o)
data_i  input  width_p  serial word
yumi_o  output  1  word consumed this cycle; only asserted when valid_i=1
valid_o  output  1  parallel frame available
data_o  output  els_p*width_p (packed [els_p-1:0][width_p-1:0])  parallel frame
ready_and_i  input  1  downstream accepts frame when valid_o & ready_and_i

Behaviour:
- Reset (reset_n_i=0, async assert, sync deassert at the source): ctr_r=0, full_r=0, out_v_r=0; valid_o=0, yumi_o=0. data_o contents are don't-care. A reset mid-frame discards partial words and any held frame.
- ctr_r is $clog2(els_p) bits wide, minimum 1 bit. It counts 0..els_p-1 and returns to 0 after the last word. There is no other wrap state.
- Word slot: idx = hi_to_lo_p ? els_p-1-ctr_r : ctr_r. On yumi_o, asm_r[idx] <= data_i.
- use_minimal_buffering_p=0:
  - last = (ctr_r==els_p-1).
  - yumi_o = valid_i & (~last | ~out_v_r | ready_and_i). There is a combinational path from ready_and_i to yumi_o only on the last word.
  - When yumi_o & last: out_r <= {asm_r with data_i merged into slot idx}, and out_v_r <= 1.
  - Else when ready_and_i & out_v_r: out_v_r <= 0.
  - valid_o=out_v_r; data_o=out_r.
  - Latency: frame visible the cycle after its last word is consumed.
  - Full throughput: a new frame may complete in the same cycle the old frame is dequeued.
- use_minimal_buffering_p=1:
  - yumi_o = valid_i & ~full_r.
  - Consuming the last word sets full_r. valid_o=full_r; data_o=asm_r.
  - ready_and_i & full_r clears full_r; input is accepted again on the following cycle. This gives one bubble per frame and no ready_and_i-to-yumi_o path.
- els_p=1: every accepted word is a frame; ctr_r is held at 0.
- Simultaneous events:
  - Dequeue and last-word accept in the same cycle (mode 0): the new frame wins and out_v_r stays 1.
  - valid_i low mid-frame: ctr_r and the partial buffer hold indefinitely.
- data_o is stable while valid_o=1 and ready_and_i=0.
- Invariants:
  - yumi_o never asserts without valid_i.
  - valid_o never drops without ready_and_i.

Optional Feature:
BSG_SIPO_YUMI_FRAME_COUNT_EN
- Defined: adds output port frame_count_o [15:0]. It resets to 0, increments on each valid_o & ready_and_i, and wraps at 16'hFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package bsg_sipo_yumi_pkg holds:
  - function ctr_width(els_p), returning max(1,$clog2(els_p))
  - localparam frame_count_width = 16
- One natural sub-module: bsg_sipo_yumi_ctr, the word counter with wrap at els_p-1, increment enable and last flag. It is reused by both buffering modes.

Test Plan:
- Mode 0, els_p=4, hi_to_lo_p=0, valid_i always 1, data 1,2,3,4,5,… with ready_and_i=1 -> yumi_o every cycle; first frame {4,3,2,1} (data_o[0]=1) appears the cycle after word 4; back-to-back frames with no gaps.
- hi_to_lo_p=1, words A,B,C,D -> data_o[3]=A, data_o[0]=D.
- Mode 0, ready_and_i=0 after first frame, 8 words offered -> second frame buffered; yumi_o drops on word 8 (last); raising ready_and_i gives yumi_o in the same cycle and frame 2 the next cycle.
- Mode 1, ready_and_i=1, continuous input -> exactly one yumi_o=0 cycle per frame (period 5 cycles for els_p=4).
- Assert reset_n_i=0 after 2 of 4 words, release, then send 4 words -> valid_o=0 during reset; the next frame contains only the 4 post-reset words.
- BSG_SIPO_YUMI_FRAME_COUNT_EN defined, 3 frames dequeued -> frame_count_o=3; preload via force to 16'hFFFF plus 1 dequeue -> 0.
